// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder.
// Handshake: start is a request and !busy is the ready; an operation transfers on a rising edge
// where start=1 and busy=0. done pulses for one cycle when sum/cout/overflow have been updated.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, mode, cin, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, mode, cin, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed BPC bits per clock through one
// slice of chained full-adder cells and a registered carry.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus,
  output logic           dbg_state
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] r_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [BPC-1:0]   slice_sum;
  logic [BPC:0]     chain;
  logic [WIDTH-1:0] r_next;
  logic             last_slice;

  // One slice of ripple full adders; chain[BPC-1] is the carry into the slice MSB.
  always_comb begin
    chain     = '0;
    slice_sum = '0;
    chain[0]  = carry;
    for (int i = 0; i < BPC; i++) begin
      slice_sum[i] = a_reg[i] ^ b_reg[i] ^ chain[i];
      chain[i+1]   = (a_reg[i] & b_reg[i]) | (chain[i] & (a_reg[i] ^ b_reg[i]));
    end
  end

  // New slice enters at the top; after N slices the first one has reached bit 0.
  assign r_next     = WIDTH'({slice_sum, r_reg} >> BPC);
  assign last_slice = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      r_reg  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            b_reg  <= bus.mode ? ~bus.b : bus.b;
            carry  <= bus.mode ? 1'b1 : bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_reg >> BPC;
          b_reg <= b_reg >> BPC;
          r_reg <= r_next;
          carry <= chain[BPC];
          cnt   <= cnt + CW'(1);
          if (last_slice) begin
            cnt    <= '0;
            sum_q  <= r_next;
            cout_q <= chain[BPC];
            ovf_q  <= chain[BPC] ^ chain[BPC-1];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign dbg_state    = (state == RUN);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8/1, 16/4, 8/8) checked every cycle against an
// arithmetic reference model, plus literal expectations for the directed cases.
module tb_serial_adder;

  typedef struct packed {
    logic        dbg;
    logic        busy;
    logic        done;
    logic        cout;
    logic        ovf;
    logic [15:0] sum;
  } obs_t;

  typedef struct {
    int          g;
    logic        en;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          lat;
  } lit_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s [3];
  logic        mode_s  [3];
  logic        cin_s   [3];
  logic [15:0] a_s     [3];
  logic [15:0] b_s     [3];
  obs_t        dut_obs [3];
  obs_t        mdl     [3];
  int          cnt_m   [3];
  logic [17:0] pend    [3];
  int          bcnt    [3];
  lit_t        lit_q[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic int w_of(int g);
    return (g == 1) ? 16 : 8;
  endfunction

  function automatic int n_of(int g);
    return (g == 0) ? 8 : ((g == 1) ? 4 : 1);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = (g == 1) ? 16 : 8;
    localparam int B = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    serial_adder_if #(.WIDTH(W)) bus ();
    logic dbg;
    assign bus.start = start_s[g];
    assign bus.mode  = mode_s[g];
    assign bus.cin   = cin_s[g];
    assign bus.a     = a_s[g][W-1:0];
    assign bus.b     = b_s[g][W-1:0];
    serial_adder #(.WIDTH(W), .BPC(B)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg)
    );
    assign dut_obs[g] = {dbg, bus.busy, bus.done, bus.cout, bus.overflow, 16'(bus.sum)};
  end

  // Reference result {overflow, cout, sum} from plain w-bit two's-complement arithmetic.
  function automatic logic [17:0] calc(int w, logic [15:0] a, logic [15:0] b, logic cin, logic mode);
    logic [16:0] mask, full;
    logic [15:0] am, bb, s;
    logic        co, ov;
    mask = (17'd1 << w) - 17'd1;
    am   = a & mask[15:0];
    bb   = mode ? (~b & mask[15:0]) : (b & mask[15:0]);
    full = {1'b0, am} + {1'b0, bb} + (mode ? 17'd1 : {16'd0, cin});
    s    = full[15:0] & mask[15:0];
    co   = full[w];
    ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  // Model: accept when idle, deliver the precomputed result N edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 3; g++) begin
        mdl[g]   <= '0;
        cnt_m[g] <= 0;
        pend[g]  <= '0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        mdl[g].done <= 1'b0;
        if (cnt_m[g] != 0) begin
          cnt_m[g] <= cnt_m[g] - 1;
          if (cnt_m[g] == 1) begin
            mdl[g].busy <= 1'b0;
            mdl[g].dbg  <= 1'b0;
            mdl[g].done <= 1'b1;
            mdl[g].sum  <= pend[g][15:0];
            mdl[g].cout <= pend[g][16];
            mdl[g].ovf  <= pend[g][17];
          end
        end else if (start_s[g]) begin
          pend[g]     <= calc(w_of(g), a_s[g], b_s[g], cin_s[g], mode_s[g]);
          cnt_m[g]    <= n_of(g);
          mdl[g].busy <= 1'b1;
          mdl[g].dbg  <= 1'b1;
        end
      end
    end
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every-cycle model compare, reset values, literal results and busy length.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      cmp($sformatf("c%0d dbg", g),  32'(dut_obs[g].dbg),  32'(mdl[g].dbg));
      cmp($sformatf("c%0d busy", g), 32'(dut_obs[g].busy), 32'(mdl[g].busy));
      cmp($sformatf("c%0d done", g), 32'(dut_obs[g].done), 32'(mdl[g].done));
      cmp($sformatf("c%0d cout", g), 32'(dut_obs[g].cout), 32'(mdl[g].cout));
      cmp($sformatf("c%0d ovf", g),  32'(dut_obs[g].ovf),  32'(mdl[g].ovf));
      cmp($sformatf("c%0d sum", g),  32'(dut_obs[g].sum),  32'(mdl[g].sum));
      if (!rst_n) begin
        cmp($sformatf("c%0d reset outputs", g), 32'(dut_obs[g]), 32'd0);
        bcnt[g] = 0;
      end else if (dut_obs[g].busy) begin
        bcnt[g]++;
      end
      if (rst_n && dut_obs[g].done) begin
        if (lit_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL c%0d done: got done=1 expected no completion pending", g);
        end else begin
          lit_t r;
          r = lit_q.pop_front();
          cmp($sformatf("c%0d done cfg", g), 32'(g), 32'(r.g));
          if (r.en) begin
            cmp($sformatf("c%0d lit sum", g),  32'(dut_obs[g].sum),  32'(r.sum));
            cmp($sformatf("c%0d lit cout", g), 32'(dut_obs[g].cout), 32'(r.cout));
            cmp($sformatf("c%0d lit ovf", g),  32'(dut_obs[g].ovf),  32'(r.ovf));
            cmp($sformatf("c%0d busy cycles", g), 32'(bcnt[g]), 32'(r.lat));
          end
        end
        bcnt[g] = 0;
      end
    end
  end

  task automatic wait_idle(int g);
    int t;
    t = 0;
    while (dut_obs[g].busy) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        $display("FAIL c%0d timeout: busy stuck after %0d cycles, expected <= 200", g, t);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic issue(int g, logic [15:0] a, logic [15:0] b, logic cin, logic mode,
                       logic en, logic [15:0] ls, logic lc, logic lo);
    lit_t r;
    wait_idle(g);
    a_s[g]     = a;
    b_s[g]     = b;
    cin_s[g]   = cin;
    mode_s[g]  = mode;
    start_s[g] = 1'b1;
    r = '{g: g, en: en, sum: ls, cout: lc, ovf: lo, lat: n_of(g)};
    lit_q.push_back(r);
    @(posedge clk); #1;
    start_s[g] = 1'b0;
  endtask

  task automatic drain(int g);
    wait_idle(g);
    @(posedge clk); #1;
  endtask

  task automatic random_ops(int g, int cnt);
    for (int i = 0; i < cnt; i++) begin
      issue(g, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0, 16'd0, 1'b0, 1'b0);
    end
    drain(g);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      start_s[g] = 1'b0;
      mode_s[g]  = 1'b0;
      cin_s[g]   = 1'b0;
      a_s[g]     = '0;
      b_s[g]     = '0;
      bcnt[g]    = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 8/1 directed: add, carry, overflow, subtract
    issue(0, 16'h3C, 16'h0F, 1'b0, 1'b0, 1'b1, 16'h4B, 1'b0, 1'b0);
    issue(0, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0);
    issue(0, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b1, 16'h80, 1'b0, 1'b1);
    issue(0, 16'h7F, 16'h00, 1'b1, 1'b0, 1'b1, 16'h80, 1'b0, 1'b1);
    issue(0, 16'h05, 16'h07, 1'b1, 1'b1, 1'b1, 16'hFE, 1'b0, 1'b0);
    issue(0, 16'h80, 16'h01, 1'b0, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1);
    issue(0, 16'h07, 16'h05, 1'b0, 1'b1, 1'b1, 16'h02, 1'b1, 1'b0);
    drain(0);

    // start pulsed mid-operation with other operands must be ignored
    issue(0, 16'h3C, 16'h0F, 1'b0, 1'b0, 1'b1, 16'h4B, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a_s[0] = 16'hFF; b_s[0] = 16'hFF; mode_s[0] = 1'b1; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;

    // back-to-back: next start is raised in the done cycle of the previous one
    issue(0, 16'h12, 16'h34, 1'b1, 1'b0, 1'b1, 16'h47, 1'b0, 1'b0);
    issue(0, 16'h90, 16'h20, 1'b0, 1'b1, 1'b1, 16'h70, 1'b1, 1'b1);
    drain(0);

    // reset four cycles into RUN aborts the operation
    issue(0, 16'hAA, 16'h55, 1'b0, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    lit_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    issue(0, 16'h01, 16'h02, 1'b0, 1'b0, 1'b1, 16'h03, 1'b0, 1'b0);
    drain(0);
    random_ops(0, 30);

    // 16/4
    issue(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    issue(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    random_ops(1, 30);

    // 8/8
    issue(2, 16'h3C, 16'h0F, 1'b0, 1'b0, 1'b1, 16'h4B, 1'b0, 1'b0);
    issue(2, 16'h80, 16'h01, 1'b0, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1);
    random_ops(2, 30);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
